// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default sequential
// step, NOP encoding and the layout of one prefetch queue entry.
package fetch_pkg;

    // Default sequential PC increment (one 32-bit MIPS word).
    localparam int DEFAULT_PC_STEP = 4;

    // Word handed to decode when no valid instruction is available.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Queue entry for the default 32/32 configuration. The top module packs
    // entries as {instr, pc4} in exactly this field order for any width.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, occupancy count and simultaneous push/pop.
// Head entry is presented combinationally from storage on rdata.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 empty
);

    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 wr_en_s;
    logic                 rd_en_s;

    // Qualify requests so a protocol error can never corrupt pointers.
    always_comb begin
        wr_en_s = push && ((count_r != FULL_COUNT) || pop);
        rd_en_s = pop && (count_r != {CNT_WIDTH{1'b0}});
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1'b1);
            end
            count_r <= count_r + CNT_WIDTH'(wr_en_s) - CNT_WIDTH'(rd_en_s);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_WIDTH{1'b0}});

    fetch_queue_checker #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_checker (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );

endmodule

// File: rtl/fetch_queue_checker.sv
// Protocol checker for fetch_queue: no push into a full queue unless the
// head is popped in the same cycle, and no pop from an empty queue.
module fetch_queue_checker #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input logic                 clock,
    input logic                 reset,
    input logic                 flush,
    input logic                 push,
    input logic                 pop,
    input logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    no_overflow: assert property (@(posedge clock) disable iff (reset || flush)
        !(push && !pop && (count == FULL_COUNT)));

    no_underflow: assert property (@(posedge clock) disable iff (reset || flush)
        !(pop && (count == {CNT_WIDTH{1'b0}})));

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage with prefetch queue and branch redirect. Streams sequential
// addresses into a one-cycle-latency instruction memory, buffers returned
// words with their PC+step, and hands them to decode under a stall handshake.
// Optional build macro IF_STATS_EN adds stall_cycles / flush_count outputs.
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}},
    parameter int                    PC_STEP     = DEFAULT_PC_STEP,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bolha,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] instrucao,
    output logic [ADDR_WIDTH-1:0] pc4
`ifdef IF_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + ADDR_WIDTH;
    localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1'b1));
    localparam logic [CNT_WIDTH:0]    CREDIT_MAX = (CNT_WIDTH + 1)'(QUEUE_DEPTH);

    // Fetch-side state
    logic [ADDR_WIDTH-1:0]  fetch_pc_r;
    logic                   inflight_r;
    logic                   inflight_epoch_r;
    logic [ADDR_WIDTH-1:0]  inflight_pc4_r;
    logic                   epoch_r;

    // Queue interface
    logic [ENTRY_WIDTH-1:0] q_rdata_s;
    logic [CNT_WIDTH-1:0]   q_count_s;
    logic                   q_empty_s;

    logic                   head_valid_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   issue_s;
    logic [CNT_WIDTH:0]     credit_used_s;

    // Handshake and issue credit: queued + in-flight, minus this cycle's pop.
    always_comb begin
        head_valid_s  = !reset && !q_empty_s;
        pop_s         = head_valid_s && !bolha && !redirect;
        push_s        = !reset && !redirect && inflight_r && (inflight_epoch_r == epoch_r);
        credit_used_s = (CNT_WIDTH + 1)'(q_count_s) + (CNT_WIDTH + 1)'(inflight_r)
                      - (CNT_WIDTH + 1)'(pop_s);
        if (reset || redirect) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (credit_used_s < CREDIT_MAX);
        end
    end

    // PC, in-flight tag and epoch; reset beats redirect, redirect beats issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r       <= RESET_PC;
            inflight_r       <= 1'b0;
            inflight_epoch_r <= 1'b0;
            inflight_pc4_r   <= {ADDR_WIDTH{1'b0}};
            epoch_r          <= 1'b0;
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc & ALIGN_MASK;
            inflight_r <= 1'b0;
            epoch_r    <= ~epoch_r;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fetch_pc_r       <= fetch_pc_r + STEP;
                inflight_pc4_r   <= fetch_pc_r + STEP;
                inflight_epoch_r <= epoch_r;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_queue (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({mem_rdata, inflight_pc4_r}),
        .rdata (q_rdata_s),
        .count (q_count_s),
        .empty (q_empty_s)
    );

    // Output drive: memory request and decode-facing head, zeroed when idle.
    always_comb begin
        mem_req   = issue_s;
        mem_addr  = issue_s ? fetch_pc_r : {ADDR_WIDTH{1'b0}};
        valid_out = head_valid_s;
        if (head_valid_s) begin
            instrucao = q_rdata_s[ENTRY_WIDTH-1 -: DATA_WIDTH];
            pc4       = q_rdata_s[ADDR_WIDTH-1:0];
        end else begin
            instrucao = DATA_WIDTH'(NOP_INSTR);
            pc4       = {ADDR_WIDTH{1'b0}};
        end
    end

`ifdef IF_STATS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    // Saturating statistics: decode stalls on a valid head, and flushes.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            if (head_valid_s && bolha && !redirect && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (redirect && (flush_count_r != 32'hFFFF_FFFF)) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios followed
// by randomized bolha/redirect/reset traffic, checked every cycle against a
// queue-of-addresses reference model. Memory word at an address = address.
module tb_instruction_fetch_queue;

    localparam int          D      = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        bolha;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        valid_out;
    logic [31:0] instrucao;
    logic [31:0] pc4;
`ifdef IF_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    instruction_fetch_queue dut (
        .clock       (clock),
        .reset       (reset),
        .bolha       (bolha),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .valid_out   (valid_out),
        .instrucao   (instrucao),
        .pc4         (pc4)
`ifdef IF_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous instruction memory: word = its own address, one-cycle latency.
    always @(posedge clock) begin
        mem_rdata <= mem_req ? mem_addr : 32'hDEAD_BEEF;
    end

    // Reference model: addresses waiting for decode, next fetch address and
    // the single outstanding request.
    logic [31:0] q_m[$];
    logic [31:0] pc_m;
    logic [31:0] infl_addr_m;
    bit          infl_m;
    logic [31:0] stall_m;
    logic [31:0] flush_m;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance model.
    task automatic step(input bit b, input bit r, input logic [31:0] rp, input bit rs);
        bit          ev;
        bit          er;
        bit          pop;
        bit          push;
        logic [31:0] ea;
        @(negedge clock);
        bolha       = b;
        redirect    = r;
        redirect_pc = rp;
        reset       = rs;
        #1;
        ev  = !rs && (q_m.size() > 0);
        pop = ev && !b && !r;
        er  = !rs && !r && ((q_m.size() + int'(infl_m) - int'(pop)) < D);
        ea  = er ? pc_m : 32'h0;
        chk("valid_out", 32'(valid_out), 32'(ev));
        chk("instrucao", instrucao, ev ? q_m[0] : 32'h0);
        chk("pc4", pc4, ev ? (q_m[0] + 32'd4) : 32'h0);
        chk("mem_req", 32'(mem_req), 32'(er));
        chk("mem_addr", mem_addr, ea);
`ifdef IF_STATS_EN
        if (!rs) begin
            chk("stall_cycles", stall_cycles, stall_m);
            chk("flush_count", flush_count, flush_m);
        end
`endif
        push = infl_m && !r && !rs;
        if (rs) begin
            q_m.delete();
            pc_m    = RST_PC;
            infl_m  = 1'b0;
            stall_m = 32'd0;
            flush_m = 32'd0;
        end else if (r) begin
            q_m.delete();
            pc_m   = rp & 32'hFFFF_FFFC;
            infl_m = 1'b0;
            if (flush_m != 32'hFFFF_FFFF) flush_m = flush_m + 32'd1;
        end else begin
            if (ev && b && (stall_m != 32'hFFFF_FFFF)) stall_m = stall_m + 32'd1;
            if (pop) void'(q_m.pop_front());
            if (push) q_m.push_back(infl_addr_m);
            infl_m = er;
            if (er) begin
                infl_addr_m = pc_m;
                pc_m        = pc_m + 32'd4;
            end
        end
    endtask

    initial begin
        bolha       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        reset       = 1'b1;

        // Reset, then free-running fetch: pc4 = 4, 8, 12 ...
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stream_pc4_c7", pc4, 32'd24);

        // Stall from cycle 3 for 10 cycles: head holds 0x4, fetch stops when full
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_head_instr", instrucao, 32'h4);
        chk("stall_head_pc4", pc4, 32'h8);
        chk("stall_full_no_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect in cycle 5 to an unaligned target
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_n1_valid", 32'(valid_out), 32'd0);
        chk("redir_n1_addr", mem_addr, 32'h0000_0100);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_n3_pc4", pc4, 32'h0000_0104);
        chk("redir_n3_valid", 32'(valid_out), 32'd1);

        // Redirect while stalled with a full queue
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_redir_pc4", pc4, 32'h0000_0204);

        // Address wrap at the top of the 32-bit space
        step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_last_instr", instrucao, 32'hFFFF_FFFC);
        chk("wrap_last_pc4", pc4, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_next_instr", instrucao, 32'h0);
        chk("wrap_next_pc4", pc4, 32'h4);

        // Reset mid-stream overrides redirect and bolha
        step(1'b1, 1'b1, 32'h0000_0800, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_mid_req", 32'(mem_req), 32'd1);
        chk("rst_mid_addr", mem_addr, RST_PC);
        chk("rst_mid_valid", 32'(valid_out), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit          rb;
            bit          rr;
            bit          rs;
            logic [31:0] rp;
            rb = ($urandom_range(99) < 40);
            rr = ($urandom_range(99) < 6);
            rs = ($urandom_range(199) < 3);
            rp = $urandom;
            if ($urandom_range(3) == 0) rp = 32'hFFFF_FFE0 | (rp & 32'h0000_001F);
            step(rb, rr, rp, rs);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
